// File: rtl/schoolbook_serial_pkg.sv
// Shared types and width helpers for the digit-serial schoolbook multiplier.
// Imported by the interface, the partial-product row and the top.
package schoolbook_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sb_state_t;

    // Counter width for n states, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit width_ok(input int bw, input int dw);
        return (dw > 0) && (dw <= bw) && ((bw % dw) == 0);
    endfunction

endpackage

// File: rtl/schoolbook_serial_if.sv
// Start/ready/done handshake bundle for the serial multiplier.
// The master issues operands; the slave (the multiplier) returns the product.
interface schoolbook_serial_if #(
    parameter int AW = 192,
    parameter int BW = 192
);
    logic              start;
    logic [AW-1:0]     a;
    logic [BW-1:0]     b;
    logic              ready;
    logic              done;
    logic [AW+BW-1:0]  c;

    modport master (output start, a, b, input ready, done, c);
    modport slave  (input start, a, b, output ready, done, c);
endinterface

// File: rtl/schoolbook_serial_pp_row.sv
// One partial-product row: multiplicand times a single DW-bit digit of b.
// Kept separate so the multiplier mapping can be swapped without touching the FSM.
module schoolbook_pp_row #(
    parameter int AW = 192,
    parameter int DW = 16
) (
    input  logic [AW-1:0]    a,
    input  logic [DW-1:0]    d,
    output logic [AW+DW-1:0] p
);
    assign p = (AW+DW)'(a) * (AW+DW)'(d);
endmodule

// File: rtl/schoolbook_serial.sv
// Digit-serial schoolbook multiplier: one AW x DW row accumulated per cycle,
// NDIG = BW/DW run cycles, product held in c until the next completion.
module schoolbook_serial
    import schoolbook_pkg::*;
#(
    parameter int AW = 192,
    parameter int BW = 192,
    parameter int DW = 16
) (
    input  logic               clk,
    input  logic               rst,
    schoolbook_serial_if.slave bus
);
    // state | meaning
    // IDLE  | ready=1, waiting for start; operands captured on accept
    // RUN   | one digit of b per cycle added into acc, c written on last digit
    // DONE  | done pulse cycle, then back to IDLE
    localparam int NDIG = BW / DW;
    localparam int CW   = clog2_min1(NDIG);
    localparam int RW   = AW + BW;

    if (!width_ok(BW, DW)) begin : g_width_check
        $error("schoolbook_serial: BW must be a positive multiple of DW");
    end

    sb_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     a_q, a_d;
    logic [BW-1:0]     b_q, b_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [RW-1:0]     c_q, c_d;
    logic              done_q, done_d;

    logic [DW-1:0]     digit;
    logic [AW+DW-1:0]  pp;
    logic [RW-1:0]     row;
    logic [RW-1:0]     sum;

    assign digit = DW'(b_q >> (int'(cnt_q) * DW));

    schoolbook_pp_row #(.AW(AW), .DW(DW)) u_pp_row (
        .a (a_q),
        .d (digit),
        .p (pp)
    );

    assign row = RW'(pp) << (int'(cnt_q) * DW);
    assign sum = acc_q + row;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
                // Final digit: publish the completed sum on the same edge.
                if (cnt_q == CW'(NDIG - 1)) begin
                    c_d     = sum;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.c     = c_q;

endmodule

// File: tb/tb_schoolbook_serial.sv
// Bench for schoolbook_serial: three instances (DW=16, DW=1, DW=192) checked
// against a plain a*b reference with the expected handshake timing.
module tb_schoolbook_serial;
    logic clk;
    logic rst;

    logic         st  [3];
    logic [191:0] av  [3];
    logic [191:0] bv  [3];
    logic         rdy [3];
    logic         dn  [3];
    logic [383:0] cv  [3];

    int ndig [3];
    int n_checks;
    int n_fail;

    schoolbook_serial_if #(.AW(192), .BW(192)) if0 ();
    schoolbook_serial_if #(.AW(192), .BW(192)) if1 ();
    schoolbook_serial_if #(.AW(192), .BW(192)) if2 ();

    schoolbook_serial #(.AW(192), .BW(192), .DW(16))  dut0 (.clk(clk), .rst(rst), .bus(if0));
    schoolbook_serial #(.AW(192), .BW(192), .DW(1))   dut1 (.clk(clk), .rst(rst), .bus(if1));
    schoolbook_serial #(.AW(192), .BW(192), .DW(192)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.start = st[0];
    assign if0.a     = av[0];
    assign if0.b     = bv[0];
    assign if1.start = st[1];
    assign if1.a     = av[1];
    assign if1.b     = bv[1];
    assign if2.start = st[2];
    assign if2.a     = av[2];
    assign if2.b     = bv[2];
    assign rdy[0] = if0.ready;
    assign rdy[1] = if1.ready;
    assign rdy[2] = if2.ready;
    assign dn[0]  = if0.done;
    assign dn[1]  = if1.done;
    assign dn[2]  = if2.done;
    assign cv[0]  = if0.c;
    assign cv[1]  = if1.c;
    assign cv[2]  = if2.c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [383:0] mul(input logic [191:0] x, input logic [191:0] y);
        logic [383:0] xx;
        logic [383:0] yy;
        xx = {192'd0, x};
        yy = {192'd0, y};
        return xx * yy;
    endfunction

    function automatic logic [191:0] rand192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One product: lat counts edges after the accepting edge until done is seen.
    task automatic issue(input int idx, input logic [191:0] x, input logic [191:0] y,
                         output int lat, output logic [383:0] res,
                         output int busy_bad, output logic rdy_after);
        int w;
        w = 0;
        busy_bad = 0;
        while (rdy[idx] !== 1'b1 && w < 500) begin
            tick();
            w++;
        end
        av[idx] = x;
        bv[idx] = y;
        st[idx] = 1'b1;
        tick();
        st[idx] = 1'b0;
        lat = 0;
        while (dn[idx] !== 1'b1 && lat < 500) begin
            if (rdy[idx] !== 1'b0) busy_bad++;
            tick();
            lat++;
        end
        if (rdy[idx] !== 1'b0) busy_bad++;
        res = cv[idx];
        tick();
        rdy_after = rdy[idx];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rdy[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready[%0d] got %b want 1", i, rdy[i]);
            end
            n_checks++;
            if (dn[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_done[%0d] got %b want 0", i, dn[i]);
            end
            n_checks++;
            if (cv[i] !== 384'd0) begin
                n_fail++;
                $display("FAIL reset_c[%0d] got %h want 0", i, cv[i]);
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_max();
        int lat, bb;
        logic ra;
        logic [383:0] res, want;
        logic [191:0] ones;
        ones = '1;
        want = 384'd0 - (384'd1 << 193) + 384'd1;
        issue(0, ones, ones, lat, res, bb, ra);
        n_checks++;
        if (res !== want) begin
            n_fail++;
            $display("FAIL max_c got %h want %h", res, want);
        end
        n_checks++;
        if (lat != ndig[0]) begin
            n_fail++;
            $display("FAIL max_latency got %0d want %0d", lat, ndig[0]);
        end
        n_checks++;
        if (bb != 0) begin
            n_fail++;
            $display("FAIL max_ready_busy got %0d ready-high cycles want 0", bb);
        end
        n_checks++;
        if (ra !== 1'b1) begin
            n_fail++;
            $display("FAIL max_ready_after got %b want 1", ra);
        end
    endtask

    task automatic test_small();
        int lat, bb;
        logic ra;
        logic [383:0] res;
        logic [191:0] ones;
        ones = '1;
        issue(0, 192'h3, 192'h5, lat, res, bb, ra);
        n_checks++;
        if (res !== 384'hF) begin
            n_fail++;
            $display("FAIL small_c got %h want f", res);
        end
        issue(0, 192'd0, ones, lat, res, bb, ra);
        n_checks++;
        if (res !== 384'd0) begin
            n_fail++;
            $display("FAIL zero_c got %h want 0", res);
        end
        n_checks++;
        if (lat != ndig[0]) begin
            n_fail++;
            $display("FAIL zero_latency got %0d want %0d", lat, ndig[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [383:0] q[$];
        logic [383:0] want;
        logic [191:0] x, y;
        int last_acc, n_done;
        last_acc = -1;
        n_done = 0;
        x = 192'd1;
        y = 192'd1;
        av[0] = x;
        bv[0] = y;
        st[0] = 1'b1;
        for (int cyc = 0; cyc < 90; cyc++) begin
            if (dn[0] === 1'b1) begin
                want = (q.size() > 0) ? q.pop_front() : 384'd0;
                n_done++;
                n_checks++;
                if (cv[0] !== want) begin
                    n_fail++;
                    $display("FAIL b2b_c got %h want %h", cv[0], want);
                end
            end
            if (rdy[0] === 1'b1) begin
                q.push_back(mul(x, y));
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != ndig[0] + 2) begin
                        n_fail++;
                        $display("FAIL b2b_interval got %0d want %0d", cyc - last_acc, ndig[0] + 2);
                    end
                end
                last_acc = cyc;
            end
            tick();
            x = x + 192'd1;
            y = y + 192'd1;
            av[0] = x;
            bv[0] = y;
        end
        st[0] = 1'b0;
        n_checks++;
        if (n_done < 5) begin
            n_fail++;
            $display("FAIL b2b_count got %0d done pulses want at least 5", n_done);
        end
        for (int w = 0; w < 40 && rdy[0] !== 1'b1; w++) tick();
    endtask

    task automatic test_ignore();
        logic [191:0] x, y;
        logic [383:0] want;
        int w, extra;
        x = rand192();
        y = rand192();
        want = mul(x, y);
        av[0] = x;
        bv[0] = y;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (4) tick();
        av[0] = rand192();
        bv[0] = rand192();
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        w = 0;
        while (dn[0] !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        n_checks++;
        if (cv[0] !== want) begin
            n_fail++;
            $display("FAIL ignore_c got %h want %h", cv[0], want);
        end
        tick();
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (dn[0] !== 1'b0 || rdy[0] !== 1'b1) extra++;
            tick();
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL ignore_no_second_op got %0d busy cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        av[0] = rand192() | 192'd1;
        bv[0] = rand192() | 192'd1;
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++;
        if (cv[0] !== 384'd0) begin
            n_fail++;
            $display("FAIL midreset_c got %h want 0", cv[0]);
        end
        n_checks++;
        if (dn[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_done got %b want 0", dn[0]);
        end
        n_checks++;
        if (rdy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready got %b want 1", rdy[0]);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dn[0] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midreset_no_done got %0d pulses want 0", bad);
        end
    endtask

    task automatic test_sweep(input int idx, input int iters);
        int lat, bb;
        logic ra;
        logic [383:0] res;
        logic [191:0] x, y;
        for (int i = 0; i < iters; i++) begin
            x = (i == 0) ? '1 : rand192();
            y = (i == 0) ? '1 : ((i == 1) ? 192'd0 : rand192());
            if (i == 2) y = 192'd1 << $urandom_range(191, 0);
            issue(idx, x, y, lat, res, bb, ra);
            n_checks++;
            if (res !== mul(x, y)) begin
                n_fail++;
                $display("FAIL sweep%0d_c iter %0d got %h want %h", idx, i, res, mul(x, y));
            end
            n_checks++;
            if (lat != ndig[idx]) begin
                n_fail++;
                $display("FAIL sweep%0d_latency iter %0d got %0d want %0d", idx, i, lat, ndig[idx]);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        ndig[0] = 12;
        ndig[1] = 192;
        ndig[2] = 1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0;
            av[i] = '0;
            bv[i] = '0;
        end
        test_reset();
        test_max();
        test_small();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_sweep(1, 100);
        test_sweep(2, 1000);
        test_sweep(0, 50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
